// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- final pipeline stage (write-back)
//
// Purpose:
//    Takes the execute stage's registered wb_* outputs and
//    - unpacks load data from dmem or IO,
//    - selects integer and FP register-file write data,
//    - arbitrates write-port conflicts between the integer pipe and FPU
//      completions, and
//    - forwards the flush redirect to fetch.
//    When a conflict occurs, the FPU result wins and the integer-pipe write
//    is parked in a one-entry hold buffer. While that buffer is occupied,
//    upstream is stalled.
//
// Ports:
//    clk, rst             clock; asynchronous active-low reset
//    wb_inst              integer-pipe instruction in WB
//    wb_fp_inst           FPU instruction completing this cycle (NOP if none)
//    wb_alu               ALU result / load address
//    wb_fpu               FPU result
//    wb_pc4               PC+4 of wb_inst
//    wb_dmem_dout         dmem read word
//    wb_io_dout           IO read word
//    wb_redirect          redirect target
//    wb_flush             redirect request
//    rf_we/wa/wd          integer register-file write port
//    frf_we/wa/wd         FP register-file write port
//    wb_stall             hold entry occupied; upstream freezes and sends NOP
//    hold_valid/fp/rd     hold entry state, used by the ID interlock
//    redirect_valid/pc    fetch redirect
//    proto_err            sticky protocol-violation flag
// ---------------------------------------------------------------------------
module wb_stage #(
   parameter int          IO_ADDR_BIT = 31,
   parameter logic [31:0] NOP         = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] wb_inst,
   input  logic [31:0] wb_fp_inst,
   input  logic [31:0] wb_alu,
   input  logic [31:0] wb_fpu,
   input  logic [31:0] wb_pc4,
   input  logic [31:0] wb_dmem_dout,
   input  logic [31:0] wb_io_dout,
   input  logic [31:0] wb_redirect,
   input  logic        wb_flush,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        frf_we,
   output logic [4:0]  frf_wa,
   output logic [31:0] frf_wd,
   output logic        wb_stall,
   output logic        hold_valid,
   output logic        hold_fp,
   output logic [4:0]  hold_rd,
   output logic        redirect_valid,
   output logic [31:0] redirect_pc,
   output logic        proto_err
);

   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_LOADFP  = 7'b0000111;
   localparam logic [6:0] OPC_OPFP    = 7'b1010011;
   localparam logic [6:0] OPC_FMADD   = 7'b1000011;
   localparam logic [6:0] OPC_FMSUB   = 7'b1000111;
   localparam logic [6:0] OPC_FNMSUB  = 7'b1001011;
   localparam logic [6:0] OPC_FNMADD  = 7'b1001111;

   // ---------------------------------------------------------------------
   // Integer-pipe decode
   // ---------------------------------------------------------------------
   logic [6:0]  wb_opc;
   logic [4:0]  wb_rd;
   logic [2:0]  wb_f3;
   logic        wb_bubble;
   logic        wb_int_op;
   logic        wb_int_wr;
   logic        wb_fp_wr;

   assign wb_opc    = wb_inst[6:0];
   assign wb_rd     = wb_inst[11:7];
   assign wb_f3     = wb_inst[14:12];
   assign wb_bubble = (wb_inst == NOP);

   always_comb begin
      wb_int_op = 1'b0;
      case (wb_opc)
         OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OPIMM,
         OPC_JAL, OPC_JALR, OPC_LOAD: wb_int_op = 1'b1;
         default:                     wb_int_op = 1'b0;
      endcase
   end

   // Writes to x0 are not writes at all, so they can neither conflict nor hold.
   assign wb_int_wr = !wb_bubble && wb_int_op && (wb_rd != 5'd0);
   assign wb_fp_wr  = !wb_bubble && (wb_opc == OPC_LOADFP);

   // ---------------------------------------------------------------------
   // Load unpacking
   // ---------------------------------------------------------------------
   logic [31:0] ld_src;
   logic [7:0]  ld_byte;
   logic [15:0] ld_half;
   logic [31:0] ld_data;

   assign ld_src  = wb_alu[IO_ADDR_BIT] ? wb_io_dout : wb_dmem_dout;
   assign ld_half = wb_alu[1] ? ld_src[31:16] : ld_src[15:0];

   always_comb begin
      case (wb_alu[1:0])
         2'd0:    ld_byte = ld_src[7:0];
         2'd1:    ld_byte = ld_src[15:8];
         2'd2:    ld_byte = ld_src[23:16];
         default: ld_byte = ld_src[31:24];
      endcase
   end

   always_comb begin
      case (wb_f3)
         3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};   // LB
         3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};  // LH
         3'b100:  ld_data = {24'd0, ld_byte};              // LBU
         3'b101:  ld_data = {16'd0, ld_half};              // LHU
         default: ld_data = ld_src;                        // LW / FLW
      endcase
   end

   logic [31:0] wb_int_data;

   always_comb begin
      case (wb_opc)
         OPC_JAL, OPC_JALR: wb_int_data = wb_pc4;
         OPC_LOAD:          wb_int_data = ld_data;
         default:           wb_int_data = wb_alu;
      endcase
   end

   // ---------------------------------------------------------------------
   // FPU completion decode
   // ---------------------------------------------------------------------
   logic [6:0] fp_opc;
   logic [6:0] fp_f7;
   logic [4:0] fpu_rd;
   logic       fp_bubble;
   logic       fp_is_fpu;
   logic       fpu_to_int;
   logic       fpu_int_wr;
   logic       fpu_fp_wr;

   assign fp_opc    = wb_fp_inst[6:0];
   assign fp_f7     = wb_fp_inst[31:25];
   assign fpu_rd    = wb_fp_inst[11:7];
   assign fp_bubble = (wb_fp_inst == NOP);
   assign fp_is_fpu = (fp_opc == OPC_OPFP)  || (fp_opc == OPC_FMADD)  ||
                      (fp_opc == OPC_FMSUB) || (fp_opc == OPC_FNMSUB) ||
                      (fp_opc == OPC_FNMADD);

   // fmv.x.w/fclass, compares and fcvt.w produce integer results.
   assign fpu_to_int = (fp_opc == OPC_OPFP) &&
                       ((fp_f7 == 7'b1110000) || (fp_f7 == 7'b1010000) ||
                        (fp_f7 == 7'b1100000));
   assign fpu_int_wr = !fp_bubble && fp_is_fpu && fpu_to_int && (fpu_rd != 5'd0);
   assign fpu_fp_wr  = !fp_bubble && fp_is_fpu && !fpu_to_int;

   // ---------------------------------------------------------------------
   // Arbitration and hold buffer
   // ---------------------------------------------------------------------
   logic        hold_valid_q, hold_valid_d;
   logic        hold_fp_q,    hold_fp_d;
   logic [4:0]  hold_rd_q,    hold_rd_d;
   logic [31:0] hold_data_q,  hold_data_d;
   logic        proto_err_q,  proto_err_d;

   logic        int_we;
   logic [4:0]  int_wa;
   logic [31:0] int_wd;
   logic        fp_we;
   logic [4:0]  fp_wa;
   logic [31:0] fp_wd;
   logic        fpu_hits_hold;

   assign fpu_hits_hold = hold_fp_q ? fpu_fp_wr : fpu_int_wr;

   always_comb begin
      // The FPU always owns its port; the integer pipe fills in around it.
      int_we      = fpu_int_wr;
      int_wa      = fpu_rd;
      int_wd      = wb_fpu;
      fp_we       = fpu_fp_wr;
      fp_wa       = fpu_rd;
      fp_wd       = wb_fpu;
      hold_valid_d = hold_valid_q;
      hold_fp_d    = hold_fp_q;
      hold_rd_d    = hold_rd_q;
      hold_data_d  = hold_data_q;
      // Upstream must be sending NOPs while stalled; any real write is ignored.
      proto_err_d  = proto_err_q | (hold_valid_q & (wb_int_wr | wb_fp_wr));

      if (hold_valid_q) begin
         if (!fpu_hits_hold) begin
            hold_valid_d = 1'b0;
            if (hold_fp_q) begin
               fp_we = 1'b1;
               fp_wa = hold_rd_q;
               fp_wd = hold_data_q;
            end else begin
               int_we = 1'b1;
               int_wa = hold_rd_q;
               int_wd = hold_data_q;
            end
         end else if (fpu_rd == hold_rd_q) begin
            // The younger FPU result to the same register supersedes the entry.
            hold_valid_d = 1'b0;
         end
      end else begin
         if (wb_int_wr) begin
            if (fpu_int_wr) begin
               hold_valid_d = 1'b1;
               hold_fp_d    = 1'b0;
               hold_rd_d    = wb_rd;
               hold_data_d  = wb_int_data;
            end else begin
               int_we = 1'b1;
               int_wa = wb_rd;
               int_wd = wb_int_data;
            end
         end
         if (wb_fp_wr) begin
            if (fpu_fp_wr) begin
               hold_valid_d = 1'b1;
               hold_fp_d    = 1'b1;
               hold_rd_d    = wb_rd;
               hold_data_d  = ld_data;
            end else begin
               fp_we = 1'b1;
               fp_wa = wb_rd;
               fp_wd = ld_data;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_valid_q <= 1'b0;
         hold_fp_q    <= 1'b0;
         hold_rd_q    <= 5'd0;
         hold_data_q  <= 32'd0;
         proto_err_q  <= 1'b0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_fp_q    <= hold_fp_d;
         hold_rd_q    <= hold_rd_d;
         hold_data_q  <= hold_data_d;
         proto_err_q  <= proto_err_d;
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign rf_we  = int_we & rst;
   assign rf_wa  = int_wa;
   assign rf_wd  = int_wd;
   assign frf_we = fp_we & rst;
   assign frf_wa = fp_wa;
   assign frf_wd = fp_wd;

   assign wb_stall   = hold_valid_q;
   assign hold_valid = hold_valid_q;
   assign hold_fp    = hold_fp_q;
   assign hold_rd    = hold_rd_q;
   assign proto_err  = proto_err_q;

   // The flush never touches the hold entry: the held write is older.
   assign redirect_valid = wb_flush;
   assign redirect_pc    = wb_redirect;

   logic unused_bits;
   assign unused_bits = ^{wb_inst[31:15], wb_fp_inst[24:12]};

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- directed, scoreboard-checked bench for wb_stage.
// Each step drives one cycle of inputs and pushes the expected outputs.
// At the following falling edge, the expected record is popped and
// compared against the DUT outputs.
// ---------------------------------------------------------------------------
module tb_wb_stage;

   logic        clk;
   logic        rst;
   logic [31:0] wb_inst, wb_fp_inst, wb_alu, wb_fpu, wb_pc4;
   logic [31:0] wb_dmem_dout, wb_io_dout, wb_redirect;
   logic        wb_flush;
   logic        rf_we, frf_we, wb_stall, hold_valid, hold_fp;
   logic        redirect_valid, proto_err;
   logic [4:0]  rf_wa, frf_wa, hold_rd;
   logic [31:0] rf_wd, frf_wd, redirect_pc;

   wb_stage dut (
      .clk(clk), .rst(rst),
      .wb_inst(wb_inst), .wb_fp_inst(wb_fp_inst), .wb_alu(wb_alu),
      .wb_fpu(wb_fpu), .wb_pc4(wb_pc4), .wb_dmem_dout(wb_dmem_dout),
      .wb_io_dout(wb_io_dout), .wb_redirect(wb_redirect), .wb_flush(wb_flush),
      .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
      .frf_we(frf_we), .frf_wa(frf_wa), .frf_wd(frf_wd),
      .wb_stall(wb_stall), .hold_valid(hold_valid), .hold_fp(hold_fp),
      .hold_rd(hold_rd), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .proto_err(proto_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef struct {
      logic        rf_we;
      logic [4:0]  rf_wa;
      logic [31:0] rf_wd;
      logic        frf_we;
      logic [4:0]  frf_wa;
      logic [31:0] frf_wd;
      logic        stall;
      logic        hfp;
      logic [4:0]  hrd;
      logic        pe;
      logic        rv;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   logic        exp_rv  = 1'b0;
   logic [31:0] exp_rpc = 32'd0;

   function automatic logic [31:0] itype(input logic [6:0] opc, input logic [4:0] rd,
                                         input logic [2:0] f3);
      return {12'd0, 5'd0, f3, rd, opc};
   endfunction

   function automatic logic [31:0] fpop(input logic [6:0] f7, input logic [4:0] rd);
      return {f7, 5'd1, 5'd2, 3'b000, rd, 7'b1010011};
   endfunction

   task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [31:0] inst, input logic [31:0] fpi,
                        input logic [31:0] alu, input logic [31:0] fpu,
                        input logic [31:0] pc4, input logic [31:0] dm,
                        input logic [31:0] io);
      wb_inst = inst; wb_fp_inst = fpi; wb_alu = alu; wb_fpu = fpu;
      wb_pc4 = pc4; wb_dmem_dout = dm; wb_io_dout = io;
      wb_flush = 1'b0; wb_redirect = 32'd0;
   endtask

   task automatic expect_o(input logic rwe, input logic [4:0] rwa, input logic [31:0] rwd,
                           input logic fwe, input logic [4:0] fwa, input logic [31:0] fwd,
                           input logic st, input logic hfp, input logic [4:0] hrd,
                           input logic pe);
      exp_t e;
      e.rf_we = rwe; e.rf_wa = rwa; e.rf_wd = rwd;
      e.frf_we = fwe; e.frf_wa = fwa; e.frf_wd = fwd;
      e.stall = st; e.hfp = hfp; e.hrd = hrd; e.pe = pe;
      e.rv = exp_rv; e.rpc = exp_rpc;
      sb.push_back(e);
   endtask

   task automatic check_step(input string tag);
      exp_t e;
      @(negedge clk);
      checks++;
      assert (sb.size() > 0) else begin
         errors++;
         $error("FAIL %s.sb: observed empty expected entry", tag);
      end
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp({tag, ".rf_we"}, {31'd0, rf_we}, {31'd0, e.rf_we});
         if (e.rf_we) begin
            cmp({tag, ".rf_wa"}, {27'd0, rf_wa}, {27'd0, e.rf_wa});
            cmp({tag, ".rf_wd"}, rf_wd, e.rf_wd);
         end
         cmp({tag, ".frf_we"}, {31'd0, frf_we}, {31'd0, e.frf_we});
         if (e.frf_we) begin
            cmp({tag, ".frf_wa"}, {27'd0, frf_wa}, {27'd0, e.frf_wa});
            cmp({tag, ".frf_wd"}, frf_wd, e.frf_wd);
         end
         cmp({tag, ".stall"}, {31'd0, wb_stall}, {31'd0, e.stall});
         cmp({tag, ".hold_valid"}, {31'd0, hold_valid}, {31'd0, e.stall});
         if (e.stall) begin
            cmp({tag, ".hold_fp"}, {31'd0, hold_fp}, {31'd0, e.hfp});
            cmp({tag, ".hold_rd"}, {27'd0, hold_rd}, {27'd0, e.hrd});
         end
         cmp({tag, ".proto_err"}, {31'd0, proto_err}, {31'd0, e.pe});
         cmp({tag, ".redir_v"}, {31'd0, redirect_valid}, {31'd0, e.rv});
         if (e.rv) cmp({tag, ".redir_pc"}, redirect_pc, e.rpc);
      end
      $display("step %-12s rf_we=%0b rf_wa=%0d rf_wd=%h frf_we=%0b frf_wa=%0d frf_wd=%h stall=%0b pe=%0b",
               tag, rf_we, rf_wa, rf_wd, frf_we, frf_wa, frf_wd, wb_stall, proto_err);
      @(posedge clk);
      #1;
   endtask

   logic [31:0] addi5, addi1, addi0, lh6, lbu7, lw8, lb10, jal1, flw3;
   logic [31:0] fadd4, fadd3, fmvx9;

   initial begin
      addi5 = itype(7'b0010011, 5'd5, 3'b000);
      addi1 = itype(7'b0010011, 5'd1, 3'b000);
      addi0 = itype(7'b0010011, 5'd0, 3'b000);
      lh6   = itype(7'b0000011, 5'd6, 3'b001);
      lbu7  = itype(7'b0000011, 5'd7, 3'b100);
      lw8   = itype(7'b0000011, 5'd8, 3'b010);
      lb10  = itype(7'b0000011, 5'd10, 3'b000);
      jal1  = itype(7'b1101111, 5'd1, 3'b000);
      flw3  = itype(7'b0000111, 5'd3, 3'b010);
      fadd4 = fpop(7'b0000000, 5'd4);
      fadd3 = fpop(7'b0000000, 5'd3);
      fmvx9 = fpop(7'b1110000, 5'd9);

      // Reset: no writes even with a live instruction present.
      rst = 1'b0;
      drive(addi5, NOP, 32'h1234, 0, 0, 0, 0);
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("reset");
      rst = 1'b1;

      // Plain integer and load writes.
      drive(addi5, NOP, 32'h1234, 0, 0, 0, 0);
      expect_o(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
      check_step("addi");
      drive(lh6, NOP, 32'h0000_1002, 0, 0, 32'h8001_0000, 0);
      expect_o(1, 6, 32'hFFFF_8001, 0, 0, 0, 0, 0, 0, 0);
      check_step("lh");
      drive(lbu7, NOP, 32'h8000_0003, 0, 0, 32'h1111_1111, 32'hAB00_0000);
      expect_o(1, 7, 32'h0000_00AB, 0, 0, 0, 0, 0, 0, 0);
      check_step("lbu_io");
      drive(lw8, NOP, 32'h8000_0000, 0, 0, 32'h1111_1111, 32'hDEAD_BEEF);
      expect_o(1, 8, 32'hDEAD_BEEF, 0, 0, 0, 0, 0, 0, 0);
      check_step("lw_io");
      drive(lb10, NOP, 32'h0000_0402, 0, 0, 32'h0080_0000, 32'hFFFF_FFFF);
      expect_o(1, 10, 32'hFFFF_FF80, 0, 0, 0, 0, 0, 0, 0);
      check_step("lb");
      drive(jal1, NOP, 32'h0000_5555, 0, 32'h0000_0104, 0, 0);
      expect_o(1, 1, 32'h0000_0104, 0, 0, 0, 0, 0, 0, 0);
      check_step("jal");
      drive(addi0, NOP, 32'h7777, 0, 0, 0, 0);
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("x0");
      drive(NOP, fmvx9, 0, 32'h55, 0, 0, 0);
      expect_o(1, 9, 32'h55, 0, 0, 0, 0, 0, 0, 0);
      check_step("fmvx");

      // FP conflict: FLW f3 loses to FADD f4, then drains.
      drive(flw3, fadd4, 32'h100, 32'h4000_0000, 0, 32'h3F80_0000, 0);
      expect_o(0, 0, 0, 1, 4, 32'h4000_0000, 0, 0, 0, 0);
      check_step("fconf0");
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      expect_o(0, 0, 0, 1, 3, 32'h3F80_0000, 1, 1, 3, 0);
      check_step("fconf1");
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("fconf2");

      // Integer conflict: ADDI x5 loses to fmv.x.w x9.
      drive(addi5, fmvx9, 32'h77, 32'h99, 0, 0, 0);
      expect_o(1, 9, 32'h99, 0, 0, 0, 0, 0, 0, 0);
      check_step("iconf0");
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      expect_o(1, 5, 32'h77, 0, 0, 0, 1, 0, 5, 0);
      check_step("iconf1");

      // Hold kept across an FPU write to a different FP register.
      drive(flw3, fadd4, 32'h100, 32'h4000_0000, 0, 32'h3F80_0000, 0);
      expect_o(0, 0, 0, 1, 4, 32'h4000_0000, 0, 0, 0, 0);
      check_step("keep0");
      drive(NOP, fadd4, 0, 32'h0000_0011, 0, 0, 0);
      expect_o(0, 0, 0, 1, 4, 32'h0000_0011, 1, 1, 3, 0);
      check_step("keep1");
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      expect_o(0, 0, 0, 1, 3, 32'h3F80_0000, 1, 1, 3, 0);
      check_step("keep2");
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("keep3");

      // Hold superseded by a younger FPU write to the same register.
      drive(flw3, fadd4, 32'h100, 32'h4000_0000, 0, 32'h3F80_0000, 0);
      expect_o(0, 0, 0, 1, 4, 32'h4000_0000, 0, 0, 0, 0);
      check_step("sup0");
      drive(NOP, fadd3, 0, 32'h4040_0000, 0, 0, 0);
      expect_o(0, 0, 0, 1, 3, 32'h4040_0000, 1, 1, 3, 0);
      check_step("sup1");
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("sup2");

      // Flush with a hold in flight: redirect fires, held write completes.
      drive(flw3, fadd4, 32'h100, 32'h4000_0000, 0, 32'h3F80_0000, 0);
      expect_o(0, 0, 0, 1, 4, 32'h4000_0000, 0, 0, 0, 0);
      check_step("flush0");
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      wb_flush = 1'b1; wb_redirect = 32'h0000_2000;
      exp_rv = 1'b1; exp_rpc = 32'h0000_2000;
      expect_o(0, 0, 0, 1, 3, 32'h3F80_0000, 1, 1, 3, 0);
      check_step("flush1");
      exp_rv = 1'b0; exp_rpc = 32'd0;
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("flush2");

      // Protocol error: a live instruction while holding is ignored.
      drive(flw3, fadd4, 32'h100, 32'h4000_0000, 0, 32'h3F80_0000, 0);
      expect_o(0, 0, 0, 1, 4, 32'h4000_0000, 0, 0, 0, 0);
      check_step("proto0");
      drive(addi1, NOP, 32'h5, 0, 0, 0, 0);
      expect_o(0, 0, 0, 1, 3, 32'h3F80_0000, 1, 1, 3, 0);
      check_step("proto1");
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_step("proto2");
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
      check_step("proto3");

      // Reset mid-hold discards the entry and clears proto_err.
      drive(flw3, fadd4, 32'h100, 32'h4000_0000, 0, 32'h3F80_0000, 0);
      expect_o(0, 0, 0, 1, 4, 32'h4000_0000, 0, 0, 0, 1);
      check_step("rsth0");
      drive(NOP, NOP, 0, 0, 0, 0, 0);
      rst = 1'b0;
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("rsth1");
      rst = 1'b1;
      expect_o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      check_step("rsth2");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
Final pipeline stage, directly downstream of the execute stage. Consumes the execute stage's registered wb_* outputs and does the following:
- unpacks loads from dmem or IO;
- selects the integer and FP register-file write data;
- arbitrates write-port conflicts between the integer pipe and FPU completions;
- forwards the flush redirect to fetch.

A one-entry hold buffer absorbs a losing write and back-pressures upstream until it drains.

Parameters:
IO_ADDR_BIT, 31, address bit that selects IO read data over dmem read data for loads
NOP, 32'h0000_0013, encoding treated as bubble

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
wb_inst  in  32  integer-pipe instruction in WB
wb_fp_inst  in  32  FPU instruction completing this cycle (NOP if none)
wb_alu  in  32  ALU result / load address
wb_fpu  in  32  FPU result
wb_pc4  in  32  PC+4 of wb_inst
wb_dmem_dout  in  32  dmem read word
wb_io_dout  in  32  IO read word
wb_redirect  in  32  redirect target
wb_flush  in  1  redirect request
rf_we  out  1  integer regfile write enable
rf_wa  out  5  integer write address
rf_wd  out  32  integer write data
frf_we  out  1  FP regfile write enable
frf_wa  out  5  FP write address
frf_wd  out  32  FP write data
wb_stall  out  1  hold buffer occupied; upstream must freeze and present NOP
hold_valid  out  1  hold entry valid (for ID interlock)
hold_fp  out  1  hold entry targets FP file
hold_rd  out  5  hold entry destination
redirect_valid  out  1  fetch redirect
redirect_pc  out  32  fetch target
proto_err  out  1  sticky protocol-violation flag

Behaviour:
Reset (rst low, async): hold_valid=0, hold_fp=0, hold_rd=0, wb_stall=0, proto_err=0. While rst is low, rf_we=frf_we=0.

Integer data select, by wb_inst opcode:
- LUI/AUIPC/OP/OP-IMM: wb_alu.
- JAL/JALR: wb_pc4.
- LOAD: unpacked word.

Load unpacking:
- Source word is wb_io_dout if wb_alu[IO_ADDR_BIT] is set, else wb_dmem_dout.
- Byte/half is selected by wb_alu[1:0].
- funct3: LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- LOAD-FP (FLW) writes the unpacked word to the FP file.

FPU destination:
- OP-FP funct7 1110000/1010000/1100000 (fmv.x.w, fclass, compares, fcvt.w) target the integer file.
- All other OP-FP and FMADD-family ops target the FP file.

Write rules:
- Integer writes to rd=x0 are suppressed and never count as a conflict.
- Non-conflicting writes are combinational, in the same cycle.

Conflict: wb_inst and wb_fp_inst target the same file in the same cycle.
- The FPU result is written.
- The wb_inst result ({fp, rd, data}) is captured into the hold entry at the clock edge; hold_valid=1 next cycle.
- wb_stall = hold_valid (registered).

Drain, each cycle with hold_valid=1:
- No FPU write to the same file: write the held entry; clear it at the edge.
- FPU write to the same file with the same rd: the FPU write proceeds and the held entry is dropped (superseded; ID's WAW interlock guarantees the FPU op is younger).
- FPU write to the same file with a different rd: the FPU write proceeds; keep holding.
- The entry can be held for several cycles while back-to-back FPU completions occur.

Protocol error:
- hold_valid=1 while wb_inst is a write-producing non-NOP is a violation.
- That wb_inst is ignored and proto_err is set; it stays set until reset.

Flush:
- redirect_valid=wb_flush and redirect_pc=wb_redirect, combinational.
- A flush never kills the hold entry (the held instruction is older than the flushing one).

Reset mid-hold discards the entry.

Test Plan:
1. ADDI x5 in WB, wb_alu=0x1234 -> rf_we=1, rf_wa=5, rf_wd=0x1234 the same cycle; wb_stall=0.
2. LH x6 with wb_alu=0x0000_1002, dmem=0x8001_0000 -> rf_wd=0xFFFF_8001. LBU x7 with wb_alu=0x8000_0003, io=0xAB00_0000 -> rf_wd=0x0000_00AB.
3. FLW f3 (data 0x3F80_0000) together with FADD f4 completing (0x4000_0000) -> cycle 0: frf_wa=4. Cycle 1: wb_stall=1, frf_wa=3, frf_wd=0x3F80_0000. Cycle 2: wb_stall=0.
4. FLW f3 held, then next cycle an FPU completion to f3 -> FPU value written, hold dropped, f3 not rewritten, stall clears.
5. Hold valid, then wb_inst=ADDI x1 -> no rf write of x1, proto_err=1 sticky. Later pulse rst low -> proto_err=0, hold_valid=0.
6. wb_flush=1, wb_redirect=0x0000_2000, with hold valid -> redirect_valid=1, redirect_pc=0x2000, held write still completes.
